// File: rtl/gray_updown_ctr.sv
// Parametrised up/down Gray counter with synchronous load and terminal-count pulse.
// Define GRAY_CTR_SATURATE_EN to saturate at the bounds instead of wrapping.
module gray_updown_ctr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] MAXV = '1;

  logic [WIDTH-1:0] b, b_nxt, d_bin;
  logic             tc_nxt, at_bound;

  // Gray-to-binary of the load value: each bit is the XOR of itself and all higher bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    assign d_bin[i] = ^d[WIDTH-1:i];
  end

  always_comb begin
    b_nxt    = b;
    tc_nxt   = 1'b0;
    at_bound = up_dn ? (b == MAXV) : (b == ZERO);
    if (ld) begin
      b_nxt = d_bin;
    end else if (en) begin
`ifdef GRAY_CTR_SATURATE_EN
      // Blocked step at a bound: hold value, still flag it.
      if (at_bound) tc_nxt = 1'b1;
      else          b_nxt  = up_dn ? b + ONE : b - ONE;
`else
      b_nxt  = up_dn ? b + ONE : b - ONE;
      tc_nxt = at_bound;
`endif
    end
  end

  // q is registered from the next binary value so it changes cleanly with b.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b  <= '0;
      q  <= '0;
      tc <= 1'b0;
    end else begin
      b  <= b_nxt;
      q  <= b_nxt ^ (b_nxt >> 1);
      tc <= tc_nxt;
    end
  end

  assign bin = b;

endmodule
